// File: rtl/xphy_link_seq_if.sv
// Status/control bundle between the link sequencer and the PHY/SFP side.
// master = sequencer (drives the reset and status outputs), slave = PHY side.
interface xphy_link_seq_if;
    logic        tx_resetdone;
    logic        rx_resetdone;
    logic        tx_fault;
    logic        signal_detect;
    logic [7:0]  core_status;
    logic        pma_reset;
    logic        core_reset;
    logic        linkup;
    logic [2:0]  seq_state;
    logic [7:0]  retry_cnt;
    logic [15:0] link_drop_cnt;

    modport master (
        input  tx_resetdone, rx_resetdone, tx_fault, signal_detect, core_status,
        output pma_reset, core_reset, linkup, seq_state, retry_cnt, link_drop_cnt
    );

    modport slave (
        output tx_resetdone, rx_resetdone, tx_fault, signal_detect, core_status,
        input  pma_reset, core_reset, linkup, seq_state, retry_cnt, link_drop_cnt
    );
endinterface

// File: rtl/xphy_link_seq.sv
// 10G PHY bring-up sequencer: PMA reset pulse, resetdone wait with retry, signal wait, link debounce.
// Define XPHY_LINK_STATS_EN to build the retry and link-drop statistics counters.
module xphy_link_seq #(
    parameter int unsigned C_RST_PULSE     = 8,
    parameter int unsigned C_DONE_TIMEOUT  = 1000,
    parameter int unsigned C_LINK_DEBOUNCE = 16
) (
    input  logic            clk156,
    input  logic            reset,
    xphy_link_seq_if.master phy
);

    typedef enum logic [2:0] {
        PMA_RST   = 3'd0,
        WAIT_DONE = 3'd1,
        WAIT_SIG  = 3'd2,
        WAIT_LINK = 3'd3,
        UP        = 3'd4
    } state_e;

    localparam logic [15:0] PULSE_LAST = 16'(C_RST_PULSE - 1);
    localparam logic [15:0] TO_LAST    = 16'(C_DONE_TIMEOUT - 1);
    localparam logic [15:0] DEB_LAST   = 16'(C_LINK_DEBOUNCE - 1);

    // {tx_resetdone, rx_resetdone, tx_fault, signal_detect}
    logic [3:0] sync1_q, sync2_q;
    logic       done, sig_ok, link_good;
    logic       unused_status;

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {phy.tx_resetdone, phy.rx_resetdone, phy.tx_fault, phy.signal_detect};
            sync2_q <= sync1_q;
        end
    end

    assign done          = sync2_q[3] & sync2_q[2];
    assign sig_ok        = sync2_q[0] & ~sync2_q[1];
    assign link_good     = phy.core_status[0];
    assign unused_status = ^phy.core_status[7:1];

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        retry_inc, drop_inc;

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state_q <= PMA_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        retry_inc = 1'b0;
        drop_inc  = 1'b0;
        case (state_q)
            PMA_RST: begin
                if (cnt_q == PULSE_LAST) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    state_d = WAIT_SIG;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = PMA_RST;
                    retry_inc = 1'b1;
                end
            end
            WAIT_SIG: begin
                if (!done)       state_d = PMA_RST;
                else if (sig_ok) state_d = WAIT_LINK;
            end
            WAIT_LINK: begin
                if (!done)                 state_d = PMA_RST;
                else if (!sig_ok)          state_d = WAIT_SIG;
                else if (!link_good)       cnt_d   = '0;
                else if (cnt_q == DEB_LAST) state_d = UP;
            end
            UP: begin
                if (!done)          state_d = PMA_RST;
                else if (!sig_ok)   state_d = WAIT_SIG;
                else if (!link_good) begin
                    state_d  = WAIT_LINK;
                    drop_inc = 1'b1;
                end
            end
            default: state_d = PMA_RST;
        endcase
        // Every entry restarts the pulse/timeout/debounce period from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    logic pma_reset_q, core_reset_q, linkup_q;

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            pma_reset_q  <= 1'b1;
            core_reset_q <= 1'b1;
            linkup_q     <= 1'b0;
        end else begin
            pma_reset_q  <= (state_q == PMA_RST);
            core_reset_q <= (state_q == PMA_RST) || (state_q == WAIT_DONE) || (state_q == WAIT_SIG);
            linkup_q     <= (state_q == UP);
        end
    end

    assign phy.pma_reset  = pma_reset_q;
    assign phy.core_reset = core_reset_q;
    assign phy.linkup     = linkup_q;
    assign phy.seq_state  = state_q;

`ifdef XPHY_LINK_STATS_EN
    logic [7:0]  retry_cnt_q, retry_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        retry_cnt_d = retry_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (retry_inc && retry_cnt_q != 8'hFF)   retry_cnt_d = retry_cnt_q + 8'd1;
        if (drop_inc  && drop_cnt_q != 16'hFFFF) drop_cnt_d  = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            retry_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign phy.retry_cnt     = retry_cnt_q;
    assign phy.link_drop_cnt = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats      = retry_inc | drop_inc;
    assign phy.retry_cnt     = '0;
    assign phy.link_drop_cnt = '0;
`endif

endmodule

// File: doc/xphy_link_seq.md
XPHY_LINK_SEQ -- requirements
Module: xphy_link_seq

Interface
REQ-001 Parameter C_RST_PULSE, default 8: number of clk156 cycles pma_reset is held high per reset attempt (range 1..255).
REQ-002 Parameter C_DONE_TIMEOUT, default 1000: cycles spent in WAIT_DONE before a retry (range 1..65535).
REQ-003 Parameter C_LINK_DEBOUNCE, default 16: consecutive cycles of link-good status required to declare link up (range 1..255).
REQ-004 clk156  in  1  single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 tx_resetdone, rx_resetdone  in  1 each  transceiver reset-complete flags, asynchronous to clk156.
REQ-007 tx_fault, signal_detect  in  1 each  SFP module status, asynchronous to clk156.
REQ-008 core_status  in  8  PCS status; bit 0 = link good, bits 7:1 ignored.
REQ-009 pma_reset  out  1  reset request to transceiver/PMA.
REQ-010 core_reset  out  1  hold-reset for the MAC/PCS core.
REQ-011 linkup  out  1  debounced link-up indication.
REQ-012 seq_state  out  3  current state encoding.
REQ-013 retry_cnt  out  8  count of WAIT_DONE timeouts.
REQ-014 link_drop_cnt  out  16  count of UP-to-WAIT_LINK transitions.

Function
REQ-015 tx_resetdone, rx_resetdone, tx_fault and signal_detect each SHALL pass through a 2-flop synchronizer; "done" means both synced resetdone flags are high; "sig_ok" means synced signal_detect=1 and synced tx_fault=0.
REQ-016 State encoding SHALL be PMA_RST=0, WAIT_DONE=1, WAIT_SIG=2, WAIT_LINK=3, UP=4; codes 5..7 SHALL transition to PMA_RST on the next cycle.
REQ-017 PMA_RST: pma_reset=1 for exactly C_RST_PULSE cycles, then go to WAIT_DONE.
REQ-018 WAIT_DONE: if done, go to WAIT_SIG; otherwise, after C_DONE_TIMEOUT cycles in this state, go to PMA_RST and increment retry_cnt (saturating at 255).
REQ-019 WAIT_SIG: when sig_ok, go to WAIT_LINK; if done drops, go to PMA_RST.
REQ-020 WAIT_LINK: the debounce counter increments while core_status[0]=1 and clears to 0 when core_status[0]=0; when it reaches C_LINK_DEBOUNCE, go to UP.
REQ-021 UP: if core_status[0]=0 for any single cycle, go to WAIT_LINK and increment link_drop_cnt (saturating at 65535).
REQ-022 Exit priority in WAIT_LINK and UP: loss of done -> PMA_RST; else loss of sig_ok -> WAIT_SIG; else the link rule; none of these exits increments link_drop_cnt.
REQ-023 Outputs SHALL be registered and decoded from the state: pma_reset=1 only in PMA_RST; core_reset=1 in PMA_RST, WAIT_DONE and WAIT_SIG; linkup=1 only in UP.
REQ-024 Latency: an asynchronous input change SHALL affect the state at most 3 clk156 edges later, and the outputs 1 edge after the state.
REQ-025 The per-state cycle counter SHALL clear on every state entry, so a re-entry always restarts the full pulse, timeout or debounce period.

Reset
REQ-026 While reset=1 the block SHALL hold: state=PMA_RST, pma_reset=1, core_reset=1, linkup=0, all counters=0, all synchronizer flops=0.
REQ-027 After reset deasserts, PMA_RST SHALL last C_RST_PULSE cycles, counted from the first rising edge of clk156.
REQ-028 Reset asserted in any state SHALL take effect immediately (asynchronously), abandoning any pulse, timeout or debounce in progress.

Configuration
REQ-029 With macro XPHY_LINK_STATS_EN defined, retry_cnt and link_drop_cnt SHALL count as specified above.
REQ-030 Without XPHY_LINK_STATS_EN, both counter ports SHALL remain present but be tied to 0, and no counter registers SHALL be synthesized; state-machine behaviour SHALL be unchanged.

Verification
REQ-031 Release reset with resetdones=1, sig_ok, core_status[0]=1 -> pma_reset high 8 cycles, core_reset falls on reaching WAIT_LINK, linkup=1 16 cycles later.
REQ-032 Hold resetdones=0 for 2500 cycles -> two timeouts, retry_cnt=2 (STATS_EN), three pma_reset pulses, linkup stays 0.
REQ-033 In WAIT_LINK, toggle core_status[0] low at debounce count 10 -> count restarts, UP entered only after 16 clean cycles.
REQ-034 In UP, pulse core_status[0]=0 for one cycle -> linkup=0, state=3, link_drop_cnt +1, relock after 16 cycles; a tx_fault pulse instead -> state=2, core_reset=1, link_drop_cnt unchanged.
REQ-035 In UP, drop rx_resetdone -> PMA_RST within 4 cycles; pulse reset mid-debounce -> all outputs at reset values immediately.
